// File: rtl/tile_line_prefetcher.sv
// Text-mode tile RAM with a double-buffered line prefetcher: each tile row is copied into a back
// line buffer during the preceding scanline. Optional blinking cursor overlay: define TILE_CURSOR_EN.
module tile_line_prefetcher #(
    parameter int HTILES      = 80,
    parameter int VTILES      = 60,
    parameter int TILE_W_LOG2 = 3,
    parameter int TILE_H_LOG2 = 3,
    parameter int HCOUNT_BITS = 10,
    parameter int VCOUNT_BITS = 10,
    parameter int VTOTAL      = 525,
    parameter int DATA_W      = 8,
    localparam int ADDR_W     = $clog2(HTILES*VTILES),
    localparam int COL_W      = $clog2(HTILES),
    localparam int ROW_W      = $clog2(VTILES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prepline,
    input  logic [HCOUNT_BITS-1:0] horicount,
    input  logic [VCOUNT_BITS-1:0] vertcount,
    input  logic                   cpu_we,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic                   cpu_ready,
    output logic [DATA_W-1:0]      character,
`ifdef TILE_CURSOR_EN
    input  logic [COL_W-1:0]       cursor_col,
    input  logic [ROW_W-1:0]       cursor_row,
    output logic                   cursor_on,
`endif
    output logic                   fill_overrun
);

    localparam int DEPTH = HTILES * VTILES;
    localparam int CNT_W = $clog2(HTILES + 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic                     wr_pend_q, wr_pend_d;
    logic [COL_W-1:0]         wr_col_q, wr_col_d;
    logic                     front_sel_q, front_sel_d;
    logic                     front_valid_q, front_valid_d;
    logic                     back_valid_q, back_valid_d;
    logic                     overrun_q, overrun_d;
    logic [DATA_W-1:0]        char_q, char_d;

    logic [DATA_W-1:0]        ram_q [DEPTH];
    logic [DATA_W-1:0]        ram_rdata_q;
    logic [DATA_W-1:0]        line_q [2][HTILES];

    logic                     ram_we;
    logic                     ram_re;
    logic [ADDR_W-1:0]        ram_addr;
    logic                     back_sel;
    logic [VCOUNT_BITS-1:0]   next_line;
    logic [VCOUNT_BITS-1:0]   next_row;
    logic                     start_fill;
    logic [HCOUNT_BITS-1:0]   col;
    logic                     col_ok;
    logic [COL_W-1:0]         col_idx;

    assign cpu_ready    = (state_q == IDLE) && !prepline && !rst;
    assign character    = char_q;
    assign fill_overrun = overrun_q;
    assign back_sel     = ~front_sel_q;

    assign next_line  = (vertcount == VCOUNT_BITS'(VTOTAL - 1)) ? '0 : vertcount + VCOUNT_BITS'(1);
    assign next_row   = next_line >> TILE_H_LOG2;
    assign start_fill = (next_line[TILE_H_LOG2-1:0] == '0) && (next_row < VCOUNT_BITS'(VTILES));

    assign col     = horicount >> TILE_W_LOG2;
    assign col_ok  = col < HCOUNT_BITS'(HTILES);
    assign col_idx = col[COL_W-1:0];

`ifdef TILE_CURSOR_EN
    logic [4:0]       frame_q, frame_d;
    logic [ROW_W-1:0] fill_row_q, fill_row_d;
    logic [ROW_W-1:0] tag_q [2];
    logic [ROW_W-1:0] tag_d [2];
    logic             cursor_on_q, cursor_on_d;

    assign cursor_on = cursor_on_q;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        base_d        = base_q;
        wr_pend_d     = 1'b0;
        wr_col_d      = wr_col_q;
        front_sel_d   = front_sel_q;
        front_valid_d = front_valid_q;
        back_valid_d  = back_valid_q;
        overrun_d     = overrun_q;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        ram_addr      = cpu_addr;
`ifdef TILE_CURSOR_EN
        frame_d       = frame_q;
        fill_row_d    = fill_row_q;
        tag_d         = tag_q;
`endif

        if (state_q == FILL) begin
            if (cnt_q < CNT_W'(HTILES)) begin
                ram_re    = 1'b1;
                ram_addr  = base_q + ADDR_W'(cnt_q);
                wr_pend_d = 1'b1;
                wr_col_d  = cnt_q[COL_W-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
            end else begin
                back_valid_d = 1'b1;
                state_d      = IDLE;
`ifdef TILE_CURSOR_EN
                tag_d[back_sel] = fill_row_q;
`endif
            end
        end else if (cpu_we && cpu_ready && ({1'b0, cpu_addr} < (ADDR_W + 1)'(DEPTH))) begin
            ram_we = 1'b1;
        end

        if (prepline) begin
            // Without a fresh row at a tile-row boundary the front row is stale, so blank it;
            // inside a tile row the front buffer keeps serving the same characters.
            if (back_valid_q) begin
                front_sel_d   = ~front_sel_q;
                front_valid_d = 1'b1;
                back_valid_d  = 1'b0;
            end else if (vertcount[TILE_H_LOG2-1:0] == '0) begin
                front_valid_d = 1'b0;
            end
            if (state_q == FILL) begin
                overrun_d    = 1'b1;
                state_d      = IDLE;
                wr_pend_d    = 1'b0;
                back_valid_d = 1'b0;
            end
            if (start_fill) begin
                state_d = FILL;
                cnt_d   = '0;
                base_d  = ADDR_W'(next_row) * ADDR_W'(HTILES);
`ifdef TILE_CURSOR_EN
                fill_row_d = next_row[ROW_W-1:0];
`endif
            end
`ifdef TILE_CURSOR_EN
            if (vertcount == VCOUNT_BITS'(VTOTAL - 1)) begin
                frame_d = frame_q + 5'd1;
            end
`endif
        end

        char_d = (front_valid_q && col_ok) ? line_q[front_sel_q][col_idx] : '0;
`ifdef TILE_CURSOR_EN
        cursor_on_d = front_valid_q && col_ok && frame_q[4] &&
                      (tag_q[front_sel_q] == cursor_row) && (col_idx == cursor_col);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            base_q        <= '0;
            wr_pend_q     <= 1'b0;
            wr_col_q      <= '0;
            front_sel_q   <= 1'b0;
            front_valid_q <= 1'b0;
            back_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            char_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            base_q        <= base_d;
            wr_pend_q     <= wr_pend_d;
            wr_col_q      <= wr_col_d;
            front_sel_q   <= front_sel_d;
            front_valid_q <= front_valid_d;
            back_valid_q  <= back_valid_d;
            overrun_q     <= overrun_d;
            char_q        <= char_d;
        end
    end

`ifdef TILE_CURSOR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q     <= '0;
            fill_row_q  <= '0;
            tag_q[0]    <= '0;
            tag_q[1]    <= '0;
            cursor_on_q <= 1'b0;
        end else begin
            frame_q     <= frame_d;
            fill_row_q  <= fill_row_d;
            tag_q       <= tag_d;
            cursor_on_q <= cursor_on_d;
        end
    end
`endif

    // Single-port tile RAM: CPU writes only in IDLE, fill reads only in FILL.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_addr] <= cpu_wdata;
        end
        if (ram_re) begin
            ram_rdata_q <= ram_q[ram_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_pend_q && !rst) begin
            line_q[back_sel][wr_col_q] <= ram_rdata_q;
        end
    end

endmodule

// File: tb/tb_tile_line_prefetcher.sv
// Self-checking bench for tile_line_prefetcher: table-driven line display checks plus
// hand-written fill, overrun, CPU-hold and reset sequences, with a queue of expected characters.
module tb_tile_line_prefetcher;

    localparam int HTILES = 80;
    localparam int VTILES = 60;
    localparam int VTOTAL = 525;

    logic        clk = 1'b0;
    logic        rst;
    logic        prepline;
    logic [9:0]  horicount;
    logic [9:0]  vertcount;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic [7:0]  character;
    logic        fill_overrun;
`ifdef TILE_CURSOR_EN
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        cursor_on;
`endif

    always #5 clk = ~clk;

    tile_line_prefetcher #(
        .HTILES(HTILES), .VTILES(VTILES), .TILE_W_LOG2(3), .TILE_H_LOG2(3),
        .HCOUNT_BITS(10), .VCOUNT_BITS(10), .VTOTAL(VTOTAL), .DATA_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .prepline(prepline),
        .horicount(horicount),
        .vertcount(vertcount),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready),
        .character(character),
`ifdef TILE_CURSOR_EN
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .cursor_on(cursor_on),
`endif
        .fill_overrun(fill_overrun)
    );

    typedef struct {
        logic [9:0] h;
        logic [7:0] exp_row0;
        logic [7:0] exp_row1;
    } vec_t;

    vec_t       vecs [7];
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic prep(input int v);
        prepline  = 1'b1;
        vertcount = 10'(v);
        tick();
        prepline  = 1'b0;
    endtask

    task automatic probe(input int h, input logic [7:0] exp, input string name);
        logic [7:0] e;
        horicount = 10'(h);
        exp_q.push_back(exp);
        tick();
        e = exp_q.pop_front();
        check(name, 32'(character), 32'(e));
    endtask

    task automatic cpu_write(input int addr, input logic [7:0] data, output int waited);
        cpu_we    = 1'b1;
        cpu_addr  = 13'(addr);
        cpu_wdata = data;
        #1;
        waited = 0;
        while (!cpu_ready && waited < 300) begin
            tick();
            waited++;
        end
        if (!cpu_ready) check("write_timeout", 32'(cpu_ready), 32'd1);
        else tick();
        cpu_we = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        #1;
        n = 0;
        while (!cpu_ready && n < 300) begin
            tick();
            n++;
        end
        if (!cpu_ready) check("idle_timeout", 32'(cpu_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        vecs[0] = '{10'd0,    8'h41, 8'h10};
        vecs[1] = '{10'd8,    8'h42, 8'h11};
        vecs[2] = '{10'd15,   8'h42, 8'h11};
        vecs[3] = '{10'd47,   8'h46, 8'h15};
        vecs[4] = '{10'd632,  8'h90, 8'h5F};
        vecs[5] = '{10'd640,  8'h00, 8'h00};
        vecs[6] = '{10'd1023, 8'h00, 8'h00};

        rst = 1'b1; prepline = 1'b0; horicount = '0; vertcount = '0;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
`ifdef TILE_CURSOR_EN
        cursor_col = '0; cursor_row = '0;
`endif
        repeat (3) tick();
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_character", 32'(character), 32'd0);
        check("rst_overrun", 32'(fill_overrun), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(cpu_ready), 32'd1);
        probe(8, 8'h00, "no_front_char");

        for (int c = 0; c < HTILES; c++) begin
            cpu_write(c, 8'(8'h41 + c), w);
            cpu_write(HTILES + c, 8'(8'h10 + c), w);
            cpu_write(59 * HTILES + c, 8'(8'h20 + c), w);
        end
        cpu_write(HTILES * VTILES + 5, 8'h55, w);
        check("oor_write_accepted", 32'(w), 32'd0);

        prep(VTOTAL - 1);
        wait_idle(w);
        check("fill_len_row0", 32'(w), 32'(HTILES + 1));

        for (int v = 0; v < 8; v++) begin
            prep(v);
            for (int i = 0; i < 7; i++) probe(int'(vecs[i].h), vecs[i].exp_row0, $sformatf("row0_l%0d_h%0d", v, vecs[i].h));
        end
        wait_idle(w);
        check("fill_len_row1", 32'(w), 32'(HTILES + 1 - 7));
        prep(8);
        for (int i = 0; i < 7; i++) probe(int'(vecs[i].h), vecs[i].exp_row1, $sformatf("row1_l8_h%0d", vecs[i].h));

        prep(VTOTAL - 1);
        cpu_write(5, 8'h7F, w);
        check("write_held_in_fill", 32'(w), 32'(HTILES + 1));
        prep(0);
        probe(47, 8'h46, "col5_before_refetch");
        prep(VTOTAL - 1);
        wait_idle(w);
        prep(0);
        probe(47, 8'h7F, "col5_after_refetch");
        probe(32, 8'h45, "col4_unchanged");

        prep(471);
        wait_idle(w);
        prep(472);
        probe(0, 8'h20, "row59_col0");
        prep(479);
        #1;
        check("no_fill_at_479", 32'(cpu_ready), 32'd1);
        probe(8, 8'h21, "row59_held_l479");
        prep(480);
        probe(8, 8'h00, "blank_l480");
        prep(500);
        #1;
        check("no_fill_at_500", 32'(cpu_ready), 32'd1);
        probe(0, 8'h00, "blank_l500");

        check("overrun_clear", 32'(fill_overrun), 32'd0);
        prep(VTOTAL - 1);
        repeat (9) tick();
        prep(0);
        check("overrun_set", 32'(fill_overrun), 32'd1);
        prep(1);
        prep(2);
        repeat (100) tick();
        check("overrun_sticky", 32'(fill_overrun), 32'd1);
        rst = 1'b1;
        tick();
        check("overrun_rst", 32'(fill_overrun), 32'd0);
        rst = 1'b0;

        prep(VTOTAL - 1);
        prep(0);
        probe(0, 8'h00, "pre_midfill");
        prep(VTOTAL - 1);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check("midfill_rst_char", 32'(character), 32'd0);
        check("midfill_rst_ready", 32'(cpu_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("midfill_ready_after", 32'(cpu_ready), 32'd1);
        check("midfill_no_overrun", 32'(fill_overrun), 32'd0);
        prep(VTOTAL - 1);
        wait_idle(w);
        check("fill_len_after_rst", 32'(w), 32'(HTILES + 1));
        prep(0);
        probe(47, 8'h7F, "ram_intact_col5");
        probe(0, 8'h41, "ram_intact_col0");
        probe(632, 8'h90, "ram_intact_col79");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
